buffered_uart: RTL and testbench

BUFFERED_UART -- requirements
Module: buffered_uart

---
 rtl/buffered_uart.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_buffered_uart.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffered_uart.sv
// Buffered UART: byte-lane programmable divider, TX/RX FIFOs, framed serial TX/RX
// with optional parity, sticky error flags and a registered interrupt.
//
// TX state | meaning                      RX state | meaning
// IDLE     | line high, wait for FIFO     IDLE     | wait for synchronised low
// START    | drive start bit (0)          START    | half-bit check of start bit
// DATA     | shift data bits, LSB first   DATA     | sample data bits, LSB first
// PARITY   | drive parity bit             PARITY   | sample and check parity bit
// STOP     | drive STOP_BITS ones         STOP     | check stop bit, then wait for line high on error

module buffered_uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // a push into a full FIFO is accepted when a pop frees a slot in the same cycle
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)
                count <= count + CNT_ONE;
            else if (do_pop && !do_push)
                count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module buffered_uart #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_RESET  = 400
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ser_tx,
    input  logic        ser_rx,
    input  logic [3:0]  reg_div_we,
    input  logic [31:0] reg_div_di,
    output logic [31:0] reg_div_do,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    output logic        reg_dat_wait,
    input  logic        reg_sta_we,
    input  logic [31:0] reg_sta_di,
    output logic [31:0] reg_sta_do,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [31:0] cfg_divider;
    logic [31:0] div_eff;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_divider <= 32'(DIV_RESET);
        end else begin
            for (int i = 0; i < 4; i++)
                if (reg_div_we[i]) cfg_divider[8*i +: 8] <= reg_div_di[8*i +: 8];
        end
    end

    // timers reload from div_eff at each bit boundary, so a divider write never cuts a bit short
    assign div_eff    = (cfg_divider < 32'd4) ? 32'd4 : cfg_divider;
    assign reg_div_do = cfg_divider;

    logic                 tx_push, tx_pop, tx_empty, tx_full;
    logic [DATA_BITS-1:0] tx_head;
    logic [CW-1:0]        tx_count;

    assign tx_push      = reg_dat_we && !tx_full;
    assign reg_dat_wait = reg_dat_we && tx_full;
    assign tx_empty     = (tx_count == '0);
    assign tx_full      = (tx_count == FIFO_FULL);

    buffered_uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (reg_dat_di[DATA_BITS-1:0]),
        .dout   (tx_head),
        .count  (tx_count)
    );

    tx_state_t            tx_state, tx_state_n;
    logic [31:0]          tx_timer, tx_timer_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic [3:0]           tx_bitn, tx_bitn_n;
    logic                 tx_par, tx_par_n;
    logic                 tx_load;
    logic                 tx_line_n;
    logic                 ser_tx_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_shift <= '0;
            tx_bitn  <= '0;
            tx_par   <= 1'b0;
            ser_tx_q <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_timer <= tx_timer_n;
            tx_shift <= tx_shift_n;
            tx_bitn  <= tx_bitn_n;
            tx_par   <= tx_par_n;
            ser_tx_q <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_timer_n = (tx_timer != 32'd0) ? tx_timer - 32'd1 : tx_timer;
        tx_shift_n = tx_shift;
        tx_bitn_n  = tx_bitn;
        tx_par_n   = tx_par;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE:   tx_load = !tx_empty;
            TX_START:  if (tx_timer == 32'd0) begin
                           tx_state_n = TX_DATA;
                           tx_timer_n = div_eff;
                           tx_bitn_n  = '0;
                       end
            TX_DATA:   if (tx_timer == 32'd0) begin
                           tx_shift_n = tx_shift >> 1;
                           tx_timer_n = div_eff;
                           if (tx_bitn == 4'(DATA_BITS - 1)) begin
                               tx_state_n = (PARITY != 0) ? TX_PARITY : TX_STOP;
                               tx_bitn_n  = '0;
                           end else begin
                               tx_bitn_n = tx_bitn + 4'd1;
                           end
                       end
            TX_PARITY: if (tx_timer == 32'd0) begin
                           tx_state_n = TX_STOP;
                           tx_timer_n = div_eff;
                           tx_bitn_n  = '0;
                       end
            TX_STOP:   if (tx_timer == 32'd0) begin
                           if (tx_bitn == 4'(STOP_BITS - 1)) begin
                               tx_state_n = TX_IDLE;
                               tx_load    = !tx_empty;
                           end else begin
                               tx_bitn_n  = tx_bitn + 4'd1;
                               tx_timer_n = div_eff;
                           end
                       end
            default:   tx_state_n = TX_IDLE;
        endcase
        // loading straight from the last stop bit keeps back-to-back frames gapless
        if (tx_load) begin
            tx_state_n = TX_START;
            tx_timer_n = div_eff;
            tx_shift_n = tx_head;
            tx_par_n   = (PARITY == 1) ? ~^tx_head : ^tx_head;
        end
        tx_pop = tx_load;
        case (tx_state_n)
            TX_START:  tx_line_n = 1'b0;
            TX_DATA:   tx_line_n = tx_shift_n[0];
            TX_PARITY: tx_line_n = tx_par_n;
            default:   tx_line_n = 1'b1;
        endcase
    end

    assign ser_tx = ser_tx_q;

    logic rx_s1, rx_s2;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= ser_rx;
            rx_s2 <= rx_s1;
        end
    end

    logic                 rx_push, rx_pop, rx_empty, rx_full;
    logic [DATA_BITS-1:0] rx_head;
    logic [CW-1:0]        rx_count;

    rx_state_t            rx_state, rx_state_n;
    logic [31:0]          rx_timer, rx_timer_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic [3:0]           rx_bitn, rx_bitn_n;
    logic                 rx_par_ok, rx_par_ok_n;
    logic                 rx_brk, rx_brk_n;
    logic                 set_frame, set_par, set_ovr;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FIFO_FULL);
    assign rx_pop   = reg_dat_re && !rx_empty;

    buffered_uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (rx_push),
        .pop    (reg_dat_re),
        .din    (rx_shift),
        .dout   (rx_head),
        .count  (rx_count)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_state  <= RX_IDLE;
            rx_timer  <= '0;
            rx_shift  <= '0;
            rx_bitn   <= '0;
            rx_par_ok <= 1'b1;
            rx_brk    <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            rx_timer  <= rx_timer_n;
            rx_shift  <= rx_shift_n;
            rx_bitn   <= rx_bitn_n;
            rx_par_ok <= rx_par_ok_n;
            rx_brk    <= rx_brk_n;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_timer_n  = (rx_timer != 32'd0) ? rx_timer - 32'd1 : rx_timer;
        rx_shift_n  = rx_shift;
        rx_bitn_n   = rx_bitn;
        rx_par_ok_n = rx_par_ok;
        rx_brk_n    = rx_brk;
        rx_push     = 1'b0;
        set_frame   = 1'b0;
        set_par     = 1'b0;
        set_ovr     = 1'b0;
        case (rx_state)
            // minus one absorbs the IDLE cycle so the start check lands mid-bit
            RX_IDLE:   if (!rx_s2) begin
                           rx_state_n = RX_START;
                           rx_timer_n = (div_eff >> 1) - 32'd1;
                       end
            RX_START:  if (rx_timer == 32'd0) begin
                           if (rx_s2) begin
                               rx_state_n = RX_IDLE;
                           end else begin
                               rx_state_n  = RX_DATA;
                               rx_timer_n  = div_eff;
                               rx_bitn_n   = '0;
                               rx_par_ok_n = 1'b1;
                           end
                       end
            RX_DATA:   if (rx_timer == 32'd0) begin
                           rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
                           rx_timer_n = div_eff;
                           if (rx_bitn == 4'(DATA_BITS - 1)) begin
                               rx_state_n = (PARITY != 0) ? RX_PARITY : RX_STOP;
                               rx_bitn_n  = '0;
                           end else begin
                               rx_bitn_n = rx_bitn + 4'd1;
                           end
                       end
            RX_PARITY: if (rx_timer == 32'd0) begin
                           rx_par_ok_n = (PARITY == 1) ? (^{rx_shift, rx_s2}) : !(^{rx_shift, rx_s2});
                           rx_state_n  = RX_STOP;
                           rx_timer_n  = div_eff;
                       end
            RX_STOP:   if (rx_brk) begin
                           if (rx_s2) begin
                               rx_brk_n   = 1'b0;
                               rx_state_n = RX_IDLE;
                           end
                       end else if (rx_timer == 32'd0) begin
                           if (!rx_s2) begin
                               set_frame = 1'b1;
                               rx_brk_n  = 1'b1;
                           end else begin
                               rx_state_n = RX_IDLE;
                               if (!rx_par_ok)
                                   set_par = 1'b1;
                               else if (rx_full && !rx_pop)
                                   set_ovr = 1'b1;
                               else
                                   rx_push = 1'b1;
                           end
                       end
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    logic [2:0] errs;
    logic [2:0] err_clr;
    logic       rx_irq_en, tx_irq_en;
    logic       tx_busy;

    assign err_clr = reg_sta_we ? reg_sta_di[7:5] : 3'b000;
    assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            errs      <= 3'b000;
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            irq       <= 1'b0;
        end else begin
            errs <= (errs & ~err_clr) | {set_ovr, set_par, set_frame};
            if (reg_sta_we) begin
                rx_irq_en <= reg_sta_di[8];
                tx_irq_en <= reg_sta_di[9];
            end
            irq <= (rx_irq_en && (!rx_empty || (errs != 3'b000))) || (tx_irq_en && tx_empty);
        end
    end

    assign reg_sta_do = {16'(rx_count), 6'd0, tx_irq_en, rx_irq_en, errs,
                         tx_busy, tx_full, tx_empty, rx_full, !rx_empty};
    assign reg_dat_do = rx_empty ? 32'hFFFF_FFFF : 32'(rx_head);

    logic unused_bits;
    assign unused_bits = ^{reg_dat_di[31:DATA_BITS], reg_sta_di[31:10], reg_sta_di[4:0]};
endmodule

// File: tb/tb_buffered_uart.sv
// Directed bench for buffered_uart: one no-parity instance and one even-parity
// instance, hand-computed serial frames and status words.

module tb_buffered_uart;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        ser_tx, ser_rx, dat_we, dat_re, dat_wait, sta_we, irq;
    logic [3:0]  div_we;
    logic [31:0] div_di, div_do, dat_di, dat_do, sta_di, sta_do;

    logic        ser_tx_p, ser_rx_p, dat_we_p, dat_re_p, dat_wait_p, sta_we_p, irq_p;
    logic [3:0]  div_we_p;
    logic [31:0] div_di_p, div_do_p, dat_di_p, dat_do_p, sta_di_p, sta_do_p;

    buffered_uart dut (
        .clk(clk), .resetn(resetn), .ser_tx(ser_tx), .ser_rx(ser_rx),
        .reg_div_we(div_we), .reg_div_di(div_di), .reg_div_do(div_do),
        .reg_dat_we(dat_we), .reg_dat_re(dat_re), .reg_dat_di(dat_di),
        .reg_dat_do(dat_do), .reg_dat_wait(dat_wait),
        .reg_sta_we(sta_we), .reg_sta_di(sta_di), .reg_sta_do(sta_do), .irq(irq)
    );

    buffered_uart #(.PARITY(2)) dut_p (
        .clk(clk), .resetn(resetn), .ser_tx(ser_tx_p), .ser_rx(ser_rx_p),
        .reg_div_we(div_we_p), .reg_div_di(div_di_p), .reg_div_do(div_do_p),
        .reg_dat_we(dat_we_p), .reg_dat_re(dat_re_p), .reg_dat_di(dat_di_p),
        .reg_dat_do(dat_do_p), .reg_dat_wait(dat_wait_p),
        .reg_sta_we(sta_we_p), .reg_sta_di(sta_di_p), .reg_sta_do(sta_do_p), .irq(irq_p)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int bclk     = 5;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic tx_line(input bit p);
        return p ? ser_tx_p : ser_tx;
    endfunction

    function automatic logic [7:0] b2b_byte(input int f);
        return (f == 0) ? 8'h55 : 8'(8'h30 + f);
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic div_write(input bit p, input logic [3:0] we, input logic [31:0] v);
        if (p) begin div_we_p = we; div_di_p = v; end
        else   begin div_we   = we; div_di   = v; end
        @(negedge clk);
        div_we = 4'h0; div_we_p = 4'h0;
    endtask

    task automatic push(input bit p, input logic [7:0] b);
        if (p) begin dat_we_p = 1'b1; dat_di_p = 32'(b); end
        else   begin dat_we   = 1'b1; dat_di   = 32'(b); end
        @(negedge clk);
        dat_we = 1'b0; dat_we_p = 1'b0;
    endtask

    task automatic sta_write(input logic [31:0] v);
        sta_we = 1'b1; sta_di = v;
        @(negedge clk);
        sta_we = 1'b0;
    endtask

    task automatic rx_bit(input bit p, input logic v);
        if (p) ser_rx_p = v; else ser_rx = v;
        repeat (bclk) @(negedge clk);
    endtask

    task automatic rx_send(input bit p, input logic [7:0] b, input bit has_par,
                           input logic pb, input logic stp);
        rx_bit(p, 1'b0);
        for (int i = 0; i < 8; i++) rx_bit(p, b[i]);
        if (has_par) rx_bit(p, pb);
        rx_bit(p, stp);
        if (p) ser_rx_p = 1'b1; else ser_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // bits[i] is the i-th bit on the line; each must hold for exactly bclk samples
    task automatic expect_tx(input bit p, input string tag, input logic [15:0] bits, input int nbits);
        int t;
        int m;
        t = 0;
        while (tx_line(p) !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        check({tag, " start seen"}, 32'(t < 200), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            m = 0;
            for (int j = 0; j < bclk; j++) begin
                if (tx_line(p) === bits[i]) m++;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d", tag, i), 32'(m), 32'(bclk));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int m;
        int zeros;
        logic [9:0] fr;

        ser_rx = 1'b1; ser_rx_p = 1'b1;
        div_we = 4'h0; div_di = '0; dat_we = 1'b0; dat_re = 1'b0; dat_di = '0;
        sta_we = 1'b0; sta_di = '0;
        div_we_p = 4'h0; div_di_p = '0; dat_we_p = 1'b0; dat_re_p = 1'b0; dat_di_p = '0;
        sta_we_p = 1'b0; sta_di_p = '0;

        do_reset();
        check("reset status", sta_do, 32'h0000_0004);
        check("reset status par", sta_do_p, 32'h0000_0004);
        check("reset ser_tx", 32'(ser_tx), 32'd1);
        check("reset divider", div_do, 32'd400);
        check("reset irq", 32'(irq), 32'd0);
        check("reset rx data", dat_do, 32'hFFFF_FFFF);

        div_write(0, 4'b0010, 32'h0000_1200);
        check("divider lane1", div_do, 32'h0000_1290);

        sta_write(32'h0000_0200);
        repeat (2) @(negedge clk);
        check("tx irq", 32'(irq), 32'd1);
        check("tx irq_en status", sta_do, 32'h0000_0204);
        sta_write(32'h0);
        repeat (2) @(negedge clk);
        check("irq off", 32'(irq), 32'd0);

        div_write(0, 4'hF, 32'd4);
        div_write(1, 4'hF, 32'd4);
        check("divider 4", div_do, 32'd4);

        push(0, 8'hA5);
        expect_tx(0, "tx a5", 16'({1'b1, 8'hA5, 1'b0}), 10);
        repeat (2) @(negedge clk);
        check("tx idle after a5", 32'(sta_do[4:2]), 32'b001);

        push(1, 8'h07);
        expect_tx(1, "tx par 07", 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        rx_send(1, 8'h07, 1'b1, 1'b0, 1'b1);
        check("parity err", 32'(sta_do_p[6]), 32'd1);
        check("parity err count", 32'(sta_do_p[31:16]), 32'd0);
        rx_send(1, 8'h07, 1'b1, 1'b1, 1'b1);
        check("parity good count", 32'(sta_do_p[31:16]), 32'd1);
        check("parity good data", dat_do_p, 32'h0000_0007);

        div_write(0, 4'hF, 32'd2);
        check("divider 2", div_do, 32'd2);
        fork
            begin
                t = 0;
                while (ser_tx !== 1'b0 && t < 200) begin @(negedge clk); t++; end
                check("b2b start seen", 32'(t < 200), 32'd1);
                m = 0;
                for (int f = 0; f < 18; f++) begin
                    fr = {1'b1, b2b_byte(f), 1'b0};
                    for (int i = 0; i < 10; i++)
                        for (int j = 0; j < 5; j++) begin
                            if (ser_tx === fr[i]) m++;
                            @(negedge clk);
                        end
                end
                check("b2b stream", 32'(m), 32'd900);
            end
            begin
                int w;
                push(0, b2b_byte(0));
                repeat (10) @(negedge clk);
                for (int i = 1; i <= 17; i++) begin
                    dat_we = 1'b1;
                    dat_di = 32'(b2b_byte(i));
                    #1;
                    if (i == 16) check("no wait on 16th", 32'(dat_wait), 32'd0);
                    if (i == 17) begin
                        check("wait on 17th", 32'(dat_wait), 32'd1);
                        check("tx full", 32'(sta_do[3]), 32'd1);
                    end
                    w = 0;
                    while (dat_wait && w < 200) begin @(negedge clk); #1; w++; end
                    if (i == 17) check("stall released", 32'(w > 0 && w < 200), 32'd1);
                    @(negedge clk);
                end
                dat_we = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("tx empty after b2b", 32'(sta_do[4:2]), 32'b001);

        push(0, 8'h00);
        push(0, 8'h00);
        t = 0;
        while (ser_tx !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        check("abort start seen", 32'(t < 200), 32'd1);
        repeat (22) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("abort ser_tx", 32'(ser_tx), 32'd1);
        check("abort tx empty", 32'(sta_do[4:2]), 32'b001);
        check("abort divider", div_do, 32'd400);
        resetn = 1'b1;
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ser_tx !== 1'b1) zeros++;
        end
        check("abort no residue", 32'(zeros), 32'd0);

        div_write(0, 4'hF, 32'd20);
        bclk = 21;
        ser_rx = 1'b0;
        repeat (2) @(negedge clk);
        ser_rx = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch count", 32'(sta_do[31:16]), 32'd0);
        check("glitch errors", 32'(sta_do[7:5]), 32'd0);

        rx_send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("frame err", 32'(sta_do[5]), 32'd1);
        check("frame err count", 32'(sta_do[31:16]), 32'd0);
        sta_write(32'h0000_0020);
        check("frame err cleared", 32'(sta_do[5]), 32'd0);

        div_write(0, 4'hF, 32'd4);
        bclk = 5;
        for (int i = 1; i <= 17; i++) rx_send(0, 8'(i), 1'b0, 1'b0, 1'b1);
        check("rx count full", 32'(sta_do[31:16]), 32'd16);
        check("rx overrun", 32'(sta_do[7]), 32'd1);
        check("rx full", 32'(sta_do[1]), 32'd1);
        sta_write(32'h0000_0100);
        repeat (2) @(negedge clk);
        check("rx irq", 32'(irq), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("rx read %0d", i), dat_do, 32'(i));
            dat_re = 1'b1;
            @(negedge clk);
            dat_re = 1'b0;
        end
        check("rx empty data", dat_do, 32'hFFFF_FFFF);
        dat_re = 1'b1;
        @(negedge clk);
        dat_re = 1'b0;
        check("pop on empty", 32'(sta_do[31:16]), 32'd0);
        sta_write(32'h0000_01E0);
        repeat (2) @(negedge clk);
        check("irq after clear", 32'(irq), 32'd0);
        check("status after clear", sta_do, 32'h0000_0104);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
